split_mixed_cond_rx: RTL and testbench

- Receive-side counterpart of the conditional value/status producer in the split-mixed datapath.
- Takes the registered value/status stream that producer emits and decodes each beat back to its source value.
  - status=1 beats carried source+OFFSET; the offset is removed.
  - status=0 beats are override values; they pass through unchanged.
- Decoded beats are buffered in a small FIFO with valid/ready handshakes on both sides.
- Per-type beat counters and a sticky underflow flag are kept for debug and scoreboard checks.

---
 rtl/split_mixed_cond_rx.sv | 95 +++++++++
 tb/tb_split_mixed_cond_rx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/split_mixed_cond_rx.sv
// Receive-side decoder for the split-mixed value/status stream: removes OFFSET from
// status=1 beats, passes override beats through, and buffers them in a small FIFO.
module split_mixed_cond_rx #(
  parameter int WIDTH  = 8,
  parameter int OFFSET = 5,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk_e,
  input  logic             rst_e,
  input  logic             in_valid_e,
  output logic             in_ready_e,
  input  logic [WIDTH-1:0] in_val_e,
  input  logic             in_status_e,
  output logic             out_valid_e,
  input  logic             out_ready_e,
  output logic [WIDTH-1:0] out_data_e,
  output logic             out_is_override_e,
  input  logic             clr_cnt_e,
  output logic [CNT_W-1:0] cond_cnt_e,
  output logic [CNT_W-1:0] ovr_cnt_e,
  output logic             err_wrap_e
);

  localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      L_DEPTH   = DEPTH[AW:0];
  localparam logic [WIDTH-1:0] L_OFFSET  = OFFSET[WIDTH-1:0];
  localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

  // Handshake: a beat moves on an edge where valid and ready are both high.
  // in_ready_e depends only on registered occupancy, never on out_ready_e.
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_mem     [DEPTH];
  logic             r_mem_ovr [DEPTH];
  logic [CNT_W-1:0] r_cond_cnt;
  logic [CNT_W-1:0] r_ovr_cnt;
  logic             r_err_wrap;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_dec;
  logic             w_wrap;

  assign in_ready_e        = (r_count != L_DEPTH);
  assign out_valid_e       = (r_count != '0);
  assign w_push            = in_valid_e & in_ready_e;
  assign w_pop             = out_valid_e & out_ready_e;
  assign w_dec             = in_status_e ? (in_val_e - L_OFFSET) : in_val_e;
  assign w_wrap            = in_status_e & (in_val_e < L_OFFSET);
  assign out_data_e        = r_mem[r_rd_ptr];
  assign out_is_override_e = r_mem_ovr[r_rd_ptr];
  assign cond_cnt_e        = r_cond_cnt;
  assign ovr_cnt_e         = r_ovr_cnt;
  assign err_wrap_e        = r_err_wrap;

  // Storage is deliberately not reset; out_valid_e gates its meaning.
  always_ff @(posedge clk_e) begin
    if (w_push && !rst_e) begin
      r_mem[r_wr_ptr]     <= w_dec;
      r_mem_ovr[r_wr_ptr] <= ~in_status_e;
    end
  end

  always_ff @(posedge clk_e) begin
    if (rst_e) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear wins over a same-edge increment or underflow detection.
  always_ff @(posedge clk_e) begin
    if (rst_e || clr_cnt_e) begin
      r_cond_cnt <= '0;
      r_ovr_cnt  <= '0;
      r_err_wrap <= 1'b0;
    end else if (w_push) begin
      if (in_status_e && (r_cond_cnt != L_CNT_MAX)) r_cond_cnt <= r_cond_cnt + CNT_W'(1);
      if (!in_status_e && (r_ovr_cnt != L_CNT_MAX)) r_ovr_cnt <= r_ovr_cnt + CNT_W'(1);
      if (w_wrap) r_err_wrap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_split_mixed_cond_rx.sv
// Bench for split_mixed_cond_rx: directed test-plan steps plus random traffic,
// each cycle compared against a queue-based reference model.
module tb_split_mixed_cond_rx;
  localparam int WIDTH  = 8;
  localparam int OFFSET = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk_e = 1'b0;
  logic             rst_e;
  logic             in_valid_e;
  logic             in_ready_e;
  logic [WIDTH-1:0] in_val_e;
  logic             in_status_e;
  logic             out_valid_e;
  logic             out_ready_e;
  logic [WIDTH-1:0] out_data_e;
  logic             out_is_override_e;
  logic             clr_cnt_e;
  logic [CNT_W-1:0] cond_cnt_e;
  logic [CNT_W-1:0] ovr_cnt_e;
  logic             err_wrap_e;

  split_mixed_cond_rx #(.WIDTH(WIDTH), .OFFSET(OFFSET), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_e(clk_e), .rst_e(rst_e),
    .in_valid_e(in_valid_e), .in_ready_e(in_ready_e),
    .in_val_e(in_val_e), .in_status_e(in_status_e),
    .out_valid_e(out_valid_e), .out_ready_e(out_ready_e),
    .out_data_e(out_data_e), .out_is_override_e(out_is_override_e),
    .clr_cnt_e(clr_cnt_e), .cond_cnt_e(cond_cnt_e), .ovr_cnt_e(ovr_cnt_e),
    .err_wrap_e(err_wrap_e)
  );

  // clock / reset
  always #5 clk_e = ~clk_e;

  // scoreboard: expected queue of {override, data}
  logic [WIDTH:0] exp_q[$];
  int m_cond;
  int m_ovr;
  bit m_err;
  int n_cmp;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready_e), 32'(exp_q.size() != DEPTH));
    chk("out_valid", 32'(out_valid_e), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_data", 32'(out_data_e), 32'(exp_q[0][WIDTH-1:0]));
      chk("out_is_override", 32'(out_is_override_e), 32'(exp_q[0][WIDTH]));
    end
    chk("cond_cnt", 32'(cond_cnt_e), 32'(m_cond));
    chk("ovr_cnt", 32'(ovr_cnt_e), 32'(m_ovr));
    chk("err_wrap", 32'(err_wrap_e), 32'(m_err));
  endtask

  // driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic step(input bit vld, input bit stat, input int val, input bit ordy, input bit clr);
    bit push, pop;
    int dec;
    in_valid_e  = vld;
    in_status_e = stat;
    in_val_e    = val[WIDTH-1:0];
    out_ready_e = ordy;
    clr_cnt_e   = clr;
    push = vld && (exp_q.size() < DEPTH);
    pop  = ordy && (exp_q.size() > 0);
    dec  = stat ? ((val - OFFSET + 256) % 256) : val;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back({~stat, dec[WIDTH-1:0]});
    if (clr) begin
      m_cond = 0; m_ovr = 0; m_err = 0;
    end else if (push) begin
      if (stat) m_cond = (m_cond < CMAX) ? m_cond + 1 : CMAX;
      else      m_ovr  = (m_ovr  < CMAX) ? m_ovr  + 1 : CMAX;
      if (stat && val < OFFSET) m_err = 1;
    end
    @(posedge clk_e); #1;
    check_all();
  endtask

  task automatic do_reset(input bit vld);
    rst_e = 1'b1;
    in_valid_e = vld; in_status_e = 1'b0; in_val_e = 8'h55;
    out_ready_e = 1'b0; clr_cnt_e = 1'b0;
    exp_q.delete();
    m_cond = 0; m_ovr = 0; m_err = 0;
    @(posedge clk_e); #1;
    rst_e = 1'b0;
    check_all();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_e = 1'b1; in_valid_e = 0; in_status_e = 0; in_val_e = 0;
    out_ready_e = 0; clr_cnt_e = 0;
    @(posedge clk_e); #1;
    do_reset(1'b0);

    // 1: conditional beat decodes 0x0A -> 0x05
    step(1, 1, 8'h0A, 0, 0);
    chk("tp1_data", 32'(out_data_e), 32'h05);
    chk("tp1_cond", 32'(cond_cnt_e), 32'd1);

    // 2: override beat passes through once the first head is popped
    step(1, 0, 8'h33, 1, 0);
    chk("tp2_data", 32'(out_data_e), 32'h33);
    chk("tp2_ovr_flag", 32'(out_is_override_e), 32'd1);
    step(0, 0, 0, 1, 0);

    // 3: fill, ignored 5th beat, drain in order
    for (int i = 0; i < 4; i++) step(1, 1, 8'h10 + i, 0, 0);
    chk("tp3_full", 32'(in_ready_e), 32'd0);
    step(1, 1, 8'h99, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("tp3_ready_after_pop", 32'(in_ready_e), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

    // 4: underflow wraps and is sticky until clear; clear beats a same-edge increment
    step(1, 1, 8'h03, 0, 0);
    chk("tp4_wrap_data", 32'(out_data_e), 32'hFE);
    step(0, 0, 0, 0, 0);
    chk("tp4_sticky", 32'(err_wrap_e), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("tp4_head_kept", 32'(out_data_e), 32'hFE);
    step(1, 1, 8'h02, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // 5: streaming with alternating status
    for (int i = 0; i < 20; i++) step(1, i[0], $urandom_range(0, 255), 1, 0);
    step(0, 0, 0, 1, 0);

    // counter saturation
    for (int i = 0; i < 270; i++) step(1, 1, $urandom_range(0, 255), 1, 0);
    chk("sat_cond", 32'(cond_cnt_e), 32'(CMAX));
    step(0, 0, 0, 1, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 255),
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);

    // 6: reset discards buffered beats
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1, i[0], 8'h40 + i, 0, 0);
    do_reset(1'b1);
    step(1, 0, 8'h7F, 0, 0);
    chk("tp6_head", 32'(out_data_e), 32'h7F);
    step(0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
